// File: rtl/iiitb_rc_monitor.sv
// Ring-counter monitor: synchronizes a 4-bit pad pattern and checks it follows the
// one-hot right rotation 1000->0100->0010->0001, counting rotations and mismatches.
module iiitb_rc_monitor #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic [3:0]       rc_in,
   input  logic             en,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [3:0]       exp,
   output logic [CNT_W-1:0] rot_cnt,
   output logic [7:0]       err_cnt
);

   localparam int unsigned RC_W    = 4;
   localparam int unsigned ERR_W   = 8;
   localparam int unsigned CHAIN_W = SYNC_STAGES * RC_W;

   localparam logic [RC_W-1:0]  PAT_HEAD   = 4'b1000;
   localparam logic [RC_W-1:0]  PAT_SECOND = 4'b0100;
   localparam logic [RC_W-1:0]  PAT_TAIL   = 4'b0001;
   localparam logic [ERR_W-1:0] ERR_MAX    = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   state_t             state;
   logic [CHAIN_W-1:0] sync_chain;
   logic [RC_W-1:0]    s;

   // Synchronizer chain: newest sample enters at the low nibble, s is the oldest.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sync_chain <= '0;
      end else begin
         sync_chain <= CHAIN_W'({sync_chain, rc_in});
      end
   end

   assign s = sync_chain[CHAIN_W-1 -: RC_W];

   function automatic logic [RC_W-1:0] rot_right(input logic [RC_W-1:0] v);
      return {v[0], v[RC_W-1:1]};
   endfunction

   // Tracking FSM with registered outputs; counter clear overrides any increment.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= ST_IDLE;
         exp       <= PAT_HEAD;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         rot_cnt   <= '0;
         err_cnt   <= '0;
      end else begin
         err_pulse <= 1'b0;
         if (en) begin
            unique case (state)
               ST_IDLE, ST_ERROR: begin
                  if (s == PAT_HEAD) begin
                     state  <= ST_TRACK;
                     locked <= 1'b1;
                     exp    <= PAT_SECOND;
                  end
               end
               ST_TRACK: begin
                  if (s == exp) begin
                     exp <= rot_right(exp);
                     if (s == PAT_TAIL) begin
                        rot_cnt <= rot_cnt + CNT_W'(1);
                     end
                  end else begin
                     err_pulse <= 1'b1;
                     if (err_cnt != ERR_MAX) begin
                        err_cnt <= err_cnt + ERR_W'(1);
                     end
                     // A fresh head reseeds the rotation instead of dropping lock.
                     if (s == PAT_HEAD) begin
                        exp <= PAT_SECOND;
                     end else begin
                        state  <= ST_ERROR;
                        locked <= 1'b0;
                        exp    <= PAT_HEAD;
                     end
                  end
               end
               default: begin
                  state  <= ST_IDLE;
                  locked <= 1'b0;
                  exp    <= PAT_HEAD;
               end
            endcase
         end
         if (clr_cnt) begin
            rot_cnt <= '0;
            err_cnt <= '0;
         end
      end
   end

endmodule

// File: doc/iiitb_rc_monitor.md
IIITB_RC_MONITOR -- requirements
Module: iiitb_rc_monitor

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops on rc_in (legal 1..3).
REQ-002 SHALL have parameter CNT_W, default 16, width of rotation counter rot_cnt.
REQ-003 SHALL have port wb_clk_i  input  1  sole clock; all flops on rising edge.
REQ-004 SHALL have port wb_rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rc_in  input  4  ring-counter pattern from pads (asynchronous to wb_clk_i).
REQ-006 SHALL have port en  input  1  monitor enable; low = freeze state, exp, counters.
REQ-007 SHALL have port clr_cnt  input  1  synchronous clear of rot_cnt and err_cnt.
REQ-008 SHALL have port locked  output  1  high while in TRACK.
REQ-009 SHALL have port err_pulse  output  1  one-cycle pulse per detected mismatch.
REQ-010 SHALL have port exp  output  4  next expected pattern.
REQ-011 SHALL have port rot_cnt  output  CNT_W  completed rotations, wraps modulo 2^CNT_W.
REQ-012 SHALL have port err_cnt  output  8  mismatch count, saturates at 255.

Function
REQ-013 SHALL pass rc_in through SYNC_STAGES flops; s = last stage output; all decisions use s only.
REQ-014 SHALL implement FSM states IDLE, TRACK, ERROR; all outputs registered.
REQ-015 Legal sequence SHALL be the right-rotation 1000 -> 0100 -> 0010 -> 0001 -> 1000, one step per clock.
REQ-016 IDLE: if en and s==1000 -> TRACK, exp<=0100; else remain, exp holds 1000.
REQ-017 TRACK, en, s==exp: exp<=exp rotated right by one; if s==0001 then rot_cnt<=rot_cnt+1.
REQ-018 TRACK, en, s!=exp, s==1000: err_pulse<=1, err_cnt+1 (saturating), stay TRACK, exp<=0100 (reseed).
REQ-019 TRACK, en, s!=exp, s!=1000: err_pulse<=1, err_cnt+1 (saturating), -> ERROR, exp<=1000.
REQ-020 ERROR: if en and s==1000 -> TRACK, exp<=0100; else remain; no further err_pulse or err_cnt change.
REQ-021 Non-one-hot values of s (0000, 1100, 1111, ...) SHALL be treated as mismatches in TRACK and ignored in IDLE/ERROR.
REQ-022 en low SHALL hold state, exp, rot_cnt, err_cnt; err_pulse SHALL be 0; synchronizer keeps sampling.
REQ-023 locked SHALL be 1 exactly when state==TRACK (registered alongside state).
REQ-024 err_pulse SHALL be high for exactly the cycle after the mismatching s sample, 0 otherwise.
REQ-025 clr_cnt SHALL zero rot_cnt and err_cnt next cycle regardless of en; clr_cnt wins over a simultaneous increment; FSM and exp unaffected.
REQ-026 err_cnt at 255 SHALL stay 255 on further mismatches; err_pulse still asserts.
REQ-027 rot_cnt at 2^CNT_W-1 SHALL wrap to 0 on next completed rotation.
REQ-028 Latency: 1000 applied on rc_in before edge N -> locked high after edge N+SYNC_STAGES.

Reset
REQ-029 wb_rst_i high at a clock edge SHALL set state IDLE, exp=1000, locked=0, err_pulse=0, rot_cnt=0, err_cnt=0, synchronizer flops=0.
REQ-030 Reset SHALL take priority over en, clr_cnt and all FSM transitions, including mid-rotation.
REQ-031 After reset release, monitor SHALL require a fresh 1000 on s before locking.

Verification
REQ-032 Reset, then drive 1000,0100,0010,0001 repeating for 12 cycles -> locked=1 from cycle 3, err_pulse never 1, rot_cnt=2 or 3 per alignment, err_cnt=0.
REQ-033 While locked, force rc_in=0110 for one cycle -> one err_pulse, err_cnt=1, locked=0, state ERROR; resume pattern -> relock only after next 1000 seen.
REQ-034 While locked expecting 0010, drive 1000 -> err_pulse=1, err_cnt+1, locked stays 1, exp=0100.
REQ-035 Hold en=0 for 5 cycles mid-sequence with pattern frozen, then re-enable continuing from frozen point -> no error, counters unchanged during hold.
REQ-036 Inject 300 mismatch/resync pairs -> err_cnt=255; assert clr_cnt coincident with a rot_cnt increment -> both counters 0 next cycle.
REQ-037 Assert wb_rst_i for one cycle mid-rotation with rot_cnt=7 -> all outputs at reset values next cycle; locked returns only after 1000 plus SYNC_STAGES+1 cycles.
